// File: rtl/meta_realign.sv
`default_nettype none
// ============================================================================
// Module      : meta_realign
// Description : Byte-stream compactor placed after header decapsulation.
//               Repacks the MSB-aligned valid bytes of each input beat into
//               full DATA_WIDTH output beats; only a packet's last beat may be
//               short. Stalls upstream for one cycle when the tail spills
//               into an extra output beat.
//               Optional macro META_REALIGN_PKTLEN_EN adds o_pktLen, the
//               packet's total emitted byte count, presented with o_tail.
// Revision    : 1.0 - initial release
// ============================================================================
module meta_realign #(
  parameter int DATA_WIDTH = 512,
  parameter int BYTES      = DATA_WIDTH / 8,
  parameter int CNT_W      = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_start,
  input  logic                  i_tail,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CNT_W-1:0]      i_bytes,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic                  o_start,
  output logic                  o_tail,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_W-1:0]      o_bytes,
  output logic                  o_err
`ifdef META_REALIGN_PKTLEN_EN
  ,
  output logic [15:0]           o_pktLen
`endif
);

  localparam logic [1:0]     S_IDLE  = 2'd0;
  localparam logic [1:0]     S_PACK  = 2'd1;
  localparam logic [1:0]     S_FLUSH = 2'd2;
  localparam logic [CNT_W:0] c_full  = (CNT_W + 1)'(BYTES);

  logic [1:0]              r_state;
  logic [1:0]              w_state_nx;
  logic [DATA_WIDTH-1:0]   r_res;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_first;

  logic                    w_acc;
  logic                    w_restart;
  logic                    w_drop;
  logic                    w_proc;
  logic                    w_fits;
  logic                    w_first_eff;
  logic [CNT_W-1:0]        w_n;
  logic [CNT_W-1:0]        w_cnt_eff;
  logic [CNT_W-1:0]        w_rem;
  logic [CNT_W:0]          w_total;
  logic [DATA_WIDTH-1:0]   w_mask;
  logic [DATA_WIDTH-1:0]   w_din;
  logic [DATA_WIDTH-1:0]   w_res_eff;
  logic [2*DATA_WIDTH-1:0] w_cat;

  logic                    w_nx_valid;
  logic                    w_nx_start;
  logic                    w_nx_tail;
  logic                    w_nx_err;
  logic [DATA_WIDTH-1:0]   w_nx_data;
  logic [CNT_W-1:0]        w_nx_bytes;
  logic [DATA_WIDTH-1:0]   w_nx_res;
  logic [CNT_W-1:0]        w_nx_cnt;
  logic                    w_nx_first;

  // Upstream is only held off while the spilled tail remainder drains.
  assign o_ready   = (r_state != S_FLUSH);
  assign w_acc     = i_valid && o_ready;
  assign w_restart = w_acc && i_start;
  assign w_drop    = w_acc && !i_start && (r_state == S_IDLE);
  assign w_proc    = w_acc && (i_start || (r_state == S_PACK));

  // Oversized counts clamp to a full beat; bytes past the count are masked.
  assign w_n    = ({1'b0, i_bytes} > c_full) ? c_full[CNT_W-1:0] : i_bytes;
  assign w_mask = ~({DATA_WIDTH{1'b1}} >> {w_n, 3'b000});
  assign w_din  = i_data & w_mask;

  // A start beat (legal or aborting) begins from an empty residue.
  assign w_cnt_eff   = w_restart ? '0 : r_cnt;
  assign w_res_eff   = w_restart ? '0 : r_res;
  assign w_first_eff = w_restart | r_first;

  // Residue bytes followed by the new bytes, as one MSB-aligned stream.
  assign w_cat   = {w_res_eff, {DATA_WIDTH{1'b0}}}
                 | ({w_din, {DATA_WIDTH{1'b0}}} >> {w_cnt_eff, 3'b000});
  assign w_total = {1'b0, w_cnt_eff} + {1'b0, w_n};
  assign w_fits  = (w_total <= c_full);
  assign w_rem   = w_total[CNT_W-1:0] - c_full[CNT_W-1:0];

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state: a tail that overflows one beat detours through FLUSH.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_FLUSH: w_state_nx = S_IDLE;
      default: begin
        if (w_proc) begin
          if (!i_tail)     w_state_nx = S_PACK;
          else if (w_fits) w_state_nx = S_IDLE;
          else             w_state_nx = S_FLUSH;
        end
      end
    endcase
  end

  // Output/datapath decode: what to emit and what residue to keep.
  always_comb begin
    w_nx_valid = 1'b0;
    w_nx_start = 1'b0;
    w_nx_tail  = 1'b0;
    w_nx_data  = '0;
    w_nx_bytes = '0;
    w_nx_err   = w_drop || (w_restart && (r_state == S_PACK));
    w_nx_res   = r_res;
    w_nx_cnt   = r_cnt;
    w_nx_first = r_first;
    if (r_state == S_FLUSH) begin
      w_nx_valid = 1'b1;
      w_nx_tail  = 1'b1;
      w_nx_data  = r_res;
      w_nx_bytes = r_cnt;
      w_nx_res   = '0;
      w_nx_cnt   = '0;
      w_nx_first = 1'b0;
    end else if (w_proc) begin
      if (i_tail && w_fits) begin
        w_nx_valid = 1'b1;
        w_nx_tail  = 1'b1;
        w_nx_start = w_first_eff;
        w_nx_data  = w_cat[2*DATA_WIDTH-1 -: DATA_WIDTH];
        w_nx_bytes = w_total[CNT_W-1:0];
        w_nx_res   = '0;
        w_nx_cnt   = '0;
        w_nx_first = 1'b0;
      end else if (w_total >= c_full) begin
        w_nx_valid = 1'b1;
        w_nx_start = w_first_eff;
        w_nx_data  = w_cat[2*DATA_WIDTH-1 -: DATA_WIDTH];
        w_nx_bytes = c_full[CNT_W-1:0];
        w_nx_res   = w_cat[DATA_WIDTH-1:0];
        w_nx_cnt   = w_rem;
        w_nx_first = 1'b0;
      end else begin
        w_nx_res   = w_cat[2*DATA_WIDTH-1 -: DATA_WIDTH];
        w_nx_cnt   = w_total[CNT_W-1:0];
        w_nx_first = w_first_eff;
      end
    end
  end

  // Registered outputs and residue.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_start <= 1'b0;
      o_tail  <= 1'b0;
      o_data  <= '0;
      o_bytes <= '0;
      o_err   <= 1'b0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b0;
    end else begin
      o_valid <= w_nx_valid;
      o_start <= w_nx_start;
      o_tail  <= w_nx_tail;
      o_data  <= w_nx_data;
      o_bytes <= w_nx_bytes;
      o_err   <= w_nx_err;
      r_res   <= w_nx_res;
      r_cnt   <= w_nx_cnt;
      r_first <= w_nx_first;
    end
  end

`ifdef META_REALIGN_PKTLEN_EN
  logic [15:0]    r_len;
  logic [15:0]    r_pktLen;
  logic [15:0]    w_len_base;
  logic [CNT_W-1:0] w_len_amt;
  logic [16:0]    w_len_sum;
  logic [15:0]    w_len_sat;

  // Bytes about to be emitted this cycle, added to the running length.
  assign w_len_base = w_restart ? '0 : r_len;
  assign w_len_amt  = (r_state == S_FLUSH) ? r_cnt :
                      (i_tail && w_fits)   ? w_total[CNT_W-1:0] :
                                             c_full[CNT_W-1:0];
  assign w_len_sum  = {1'b0, w_len_base} + {{(17 - CNT_W){1'b0}}, w_len_amt};
  assign w_len_sat  = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];
  assign o_pktLen   = r_pktLen;

  // Saturating packet length; reported with the tail, then cleared.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len    <= '0;
      r_pktLen <= '0;
    end else begin
      r_pktLen <= '0;
      if (w_nx_valid && w_nx_tail) begin
        r_pktLen <= w_len_sat;
        r_len    <= '0;
      end else if (w_nx_valid) begin
        r_len <= w_len_sat;
      end else if (w_nx_err) begin
        r_len <= '0;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_meta_realign.sv
`default_nettype none
// ============================================================================
// Module      : tb_meta_realign
// Description : Bench for meta_realign. A byte-queue model predicts every
//               output cycle; directed packets pin the model with literals,
//               then randomized packets exercise the rest.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_meta_realign;
  localparam int DW = 512;
  localparam int NB = 64;
  localparam int CW = 7;

  logic          i_clk   = 1'b0;
  logic          i_rst   = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_start = 1'b0;
  logic          i_tail  = 1'b0;
  logic [DW-1:0] i_data  = '0;
  logic [CW-1:0] i_bytes = '0;
  logic          o_ready;
  logic          o_valid;
  logic          o_start;
  logic          o_tail;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_bytes;
  logic          o_err;
`ifdef META_REALIGN_PKTLEN_EN
  logic [15:0]   o_pktLen;
`endif

  meta_realign #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_start(i_start),
    .i_tail(i_tail), .i_data(i_data), .i_bytes(i_bytes), .o_ready(o_ready),
    .o_valid(o_valid), .o_start(o_start), .o_tail(o_tail), .o_data(o_data),
    .o_bytes(o_bytes), .o_err(o_err)
`ifdef META_REALIGN_PKTLEN_EN
    , .o_pktLen(o_pktLen)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Model: pending bytes of the current packet as a plain byte queue.
  logic [7:0] mq[$];
  bit m_flush = 1'b0, m_inpkt = 1'b0, m_first = 1'b0;
  int m_len = 0;
  bit e_valid = 1'b0, e_start = 1'b0, e_tail = 1'b0, e_err = 1'b0;
  logic [DW-1:0] e_data = '0;
  int e_bytes = 0, e_len = 0;

  // Logs of observed output beats for the directed literal checks.
  int            lg_bytes[$];
  bit            lg_start[$];
  bit            lg_tail[$];
  logic [DW-1:0] lg_data[$];
  int            lg_len[$];
  int            lg_err = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic chk_beat(input string nm, input int idx, input int nb, input bit st, input bit tl);
    if (idx >= lg_bytes.size()) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: beat %0d missing, only %0d beats", nm, idx, lg_bytes.size());
    end else begin
      chk({nm, " bytes"}, lg_bytes[idx], nb);
      chk({nm, " start"}, lg_start[idx], st);
      chk({nm, " tail"},  lg_tail[idx],  tl);
    end
  endtask

  task automatic chk_data(input string nm, input int idx, input logic [DW-1:0] req);
    n_vec++;
    if (idx >= lg_data.size() || lg_data[idx] !== req) begin
      n_err++;
      $display("FAIL %s: beat %0d data differs from %h", nm, idx, req);
    end
  endtask

  task automatic clr_log();
    lg_bytes.delete(); lg_start.delete(); lg_tail.delete();
    lg_data.delete(); lg_len.delete(); lg_err = 0;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic m_emit(input int k, input bit st, input bit tl);
    e_valid = 1'b1; e_start = st; e_tail = tl; e_bytes = k; e_data = '0;
    for (int i = 0; i < k; i++) e_data[DW-1-8*i -: 8] = mq.pop_front();
    m_len += k;
    if (m_len > 65535) m_len = 65535;
    if (tl) begin
      e_len = m_len;
      m_len = 0;
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_flush = 1'b0; m_inpkt = 1'b0; m_first = 1'b0; m_len = 0;
    e_valid = 1'b0; e_start = 1'b0; e_tail = 1'b0; e_err = 1'b0;
    e_data = '0; e_bytes = 0; e_len = 0;
  endtask

  // Predict the outputs that follow this clock edge.
  task automatic model_step(input bit acc);
    int n;
    e_valid = 1'b0; e_start = 1'b0; e_tail = 1'b0; e_err = 1'b0;
    e_data = '0; e_bytes = 0; e_len = 0;
    if (m_flush) begin
      m_emit(mq.size(), 1'b0, 1'b1);
      m_flush = 1'b0;
      m_inpkt = 1'b0;
      return;
    end
    if (!acc) return;
    n = (int'(i_bytes) > NB) ? NB : int'(i_bytes);
    if (!i_start && !m_inpkt) begin
      e_err = 1'b1;
      return;
    end
    if (i_start) begin
      if (m_inpkt) e_err = 1'b1;
      mq.delete();
      m_first = 1'b1;
      m_len = 0;
      m_inpkt = 1'b1;
    end
    for (int i = 0; i < n; i++) mq.push_back(i_data[DW-1-8*i -: 8]);
    if (i_tail && mq.size() <= NB) begin
      m_emit(mq.size(), m_first, 1'b1);
      m_first = 1'b0;
      m_inpkt = 1'b0;
    end else if (mq.size() >= NB) begin
      m_emit(NB, m_first, 1'b0);
      m_first = 1'b0;
      if (i_tail) m_flush = 1'b1;
    end
  endtask

  // One clock: check ready, advance model at the edge, return at negedge.
  task automatic cycle();
    bit acc;
    acc = i_valid && !m_flush;
    n_vec++;
    if (o_ready !== !m_flush) begin
      n_err++;
      $display("FAIL ready: got %b expected %b", o_ready, !m_flush);
    end
    @(posedge i_clk);
    model_step(acc);
    @(negedge i_clk);
  endtask

  task automatic send(input bit st, input bit tl, input int nb, input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    i_valid = 1'b1; i_start = st; i_tail = tl; i_bytes = CW'(nb); i_data = d;
    for (int g = 0; g < 4 && !done; g++) begin
      done = !m_flush;
      cycle();
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL accept: beat not accepted within 4 cycles");
    end
    i_valid = 1'b0; i_start = 1'b0; i_tail = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int c = 0; c < k; c++) begin
      i_valid = 1'b0;
      i_start = 1'($urandom());
      i_tail  = 1'($urandom());
      i_data  = rnd_data();
      i_bytes = CW'($urandom_range(0, 127));
      cycle();
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge i_clk) begin
    if (cmp_en && !i_rst) begin
      bit len_ok;
      int len_obs;
      len_ok = 1'b1;
      len_obs = 0;
`ifdef META_REALIGN_PKTLEN_EN
      len_ok = (o_pktLen === 16'(e_len));
      len_obs = int'(o_pktLen);
`endif
      n_vec++;
      if (o_valid !== e_valid || o_start !== e_start || o_tail !== e_tail ||
          o_err !== e_err || o_bytes !== CW'(e_bytes) || !len_ok) begin
        n_err++;
        $display("FAIL out: got v%b s%b t%b e%b n%0d len%0d expected v%b s%b t%b e%b n%0d len%0d",
                 o_valid, o_start, o_tail, o_err, o_bytes, len_obs,
                 e_valid, e_start, e_tail, e_err, e_bytes, e_len);
      end else if (o_data !== e_data) begin
        n_err++;
        $display("FAIL data: got %h expected %h", o_data, e_data);
      end
      if (o_valid === 1'b1) begin
        lg_bytes.push_back(int'(o_bytes));
        lg_start.push_back(o_start);
        lg_tail.push_back(o_tail);
        lg_data.push_back(o_data);
        lg_len.push_back(len_obs);
      end
      if (o_err === 1'b1) lg_err++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d1, d2, d3, low;
    // Reset values
    #1;
    chk("rst valid", o_valid, 0);
    chk("rst ready", o_ready, 1);
    chk("rst bytes", o_bytes, 0);
    chk("rst data", |o_data, 0);
    chk("rst err",  o_err, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    idle(1);

    // Pass-through
    clr_log();
    d1 = rnd_data(); d2 = rnd_data();
    send(1'b1, 1'b0, 64, d1);
    chk("pt latency", o_valid, 1);
    send(1'b0, 1'b1, 64, d2);
    idle(2);
    chk("pt beats", lg_bytes.size(), 2);
    chk_beat("pt b0", 0, 64, 1'b1, 1'b0);
    chk_beat("pt b1", 1, 64, 1'b0, 1'b1);
    chk_data("pt d0", 0, d1);
    chk_data("pt d1", 1, d2);

    // Decap compaction with one-cycle stall
    clr_log();
    d1 = rnd_data(); d2 = rnd_data();
    send(1'b1, 1'b0, 52, d1);
    send(1'b0, 1'b1, 64, d2);
    chk("dc ready low", o_ready, 0);
    idle(1);
    chk("dc ready back", o_ready, 1);
    idle(2);
    chk("dc beats", lg_bytes.size(), 2);
    chk_beat("dc b0", 0, 64, 1'b1, 1'b0);
    chk_beat("dc b1", 1, 52, 1'b0, 1'b1);
    chk_data("dc d0", 0, {d1[DW-1 -: 416], d2[DW-1 -: 96]});
    chk_data("dc d1", 1, {d2[415:0], 96'h0});
`ifdef META_REALIGN_PKTLEN_EN
    if (lg_len.size() >= 2) chk("dc pktlen", lg_len[1], 116);
    else chk("dc pktlen beats", lg_len.size(), 2);
`endif

    // Accumulate three short beats
    clr_log();
    d1 = rnd_data(); d2 = rnd_data(); d3 = rnd_data();
    send(1'b1, 1'b0, 20, d1);
    chk("acc no out", o_valid, 0);
    send(1'b0, 1'b0, 20, d2);
    send(1'b0, 1'b1, 20, d3);
    idle(2);
    chk("acc beats", lg_bytes.size(), 1);
    chk_beat("acc b0", 0, 60, 1'b1, 1'b1);
    chk_data("acc d0", 0, {d1[DW-1 -: 160], d2[DW-1 -: 160], d3[DW-1 -: 160], 32'h0});
    low = (lg_data.size() > 0) ? lg_data[0] : '1;
    chk("acc low zero", low[31:0], 0);

    // Zero-length tail
    clr_log();
    send(1'b1, 1'b0, 64, rnd_data());
    send(1'b0, 1'b1, 0, rnd_data());
    idle(2);
    chk("zt beats", lg_bytes.size(), 2);
    chk_beat("zt b0", 0, 64, 1'b1, 1'b0);
    chk_beat("zt b1", 1, 0, 1'b0, 1'b1);

    // Non-start beat while idle
    clr_log();
    send(1'b0, 1'b0, 40, rnd_data());
    idle(2);
    chk("idle err", lg_err, 1);
    chk("idle beats", lg_bytes.size(), 0);

    // Missing tail, restarted by a single-beat packet
    clr_log();
    d2 = rnd_data();
    send(1'b1, 1'b0, 30, rnd_data());
    send(1'b1, 1'b1, 10, d2);
    idle(2);
    chk("abort err", lg_err, 1);
    chk("abort beats", lg_bytes.size(), 1);
    chk_beat("abort b0", 0, 10, 1'b1, 1'b1);
    chk_data("abort d0", 0, {d2[DW-1 -: 80], 432'h0});

    // Asynchronous reset while in FLUSH
    send(1'b1, 1'b0, 52, rnd_data());
    send(1'b0, 1'b1, 64, rnd_data());
    chk("rf ready low", o_ready, 0);
    cmp_en = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    chk("rf valid", o_valid, 0);
    chk("rf ready", o_ready, 1);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    clr_log();
    d1 = rnd_data(); d2 = rnd_data();
    send(1'b1, 1'b0, 64, d1);
    send(1'b0, 1'b1, 64, d2);
    idle(2);
    chk("rf beats", lg_bytes.size(), 2);
    chk_beat("rf b0", 0, 64, 1'b1, 1'b0);
    chk_beat("rf b1", 1, 64, 1'b0, 1'b1);
    chk_data("rf d1", 1, d2);

    // Randomized packets against the model
    for (int p = 0; p < 300; p++) begin
      int nbeats;
      bit abort;
      nbeats = $urandom_range(1, 5);
      abort  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 14) == 0)
        send(1'b0, 1'($urandom()), $urandom_range(0, 64), rnd_data());
      for (int b = 0; b < nbeats; b++) begin
        int sel, nb;
        sel = $urandom_range(0, 9);
        if (sel < 3)       nb = 64;
        else if (sel == 3) nb = $urandom_range(65, 127);
        else               nb = $urandom_range(0, 64);
        send(b == 0, (b == nbeats - 1) && !abort, nb, rnd_data());
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle($urandom_range(0, 2));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
